// File: rtl/decoder_stream_pkg.sv
// Shared decode definitions for the Ember instruction stream decoder:
// header field positions, flag indices, FSM states and the decoded bundle type.
package ember_decode_pkg;

  localparam int HDR_W     = 32;
  localparam int OPC_LSB   = 20;
  localparam int MODE_LSB  = 16;
  localparam int RSRC_LSB  = 10;
  localparam int RDEST_LSB = 4;

  localparam int FLG_V  = 0;
  localparam int FLG_I  = 1;
  localparam int FLG_SZ = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    IMM  = 1'b1
  } state_t;

  typedef struct packed {
    logic [11:0] opcode;
    logic [3:0]  mode;
    logic [5:0]  rsrc;
    logic [5:0]  rdest;
    logic [3:0]  flags;
  } hdr_t;

  typedef struct packed {
    hdr_t hdr;
    logic imm_en;
    logic illegal;
  } bundle_t;

  function automatic hdr_t unpack_hdr(input logic [HDR_W-1:0] w);
    hdr_t h;
    h.opcode = w[OPC_LSB +: 12];
    h.mode   = w[MODE_LSB +: 4];
    h.rsrc   = w[RSRC_LSB +: 6];
    h.rdest  = w[RDEST_LSB +: 6];
    h.flags  = w[3:0];
    return h;
  endfunction

  // Size code k selects 2^k immediate words; legal only when that fits the datapath.
  function automatic logic size_legal(input logic [1:0] k, input int max_words);
    int n;
    n = 1 << k;
    return n <= max_words;
  endfunction

endpackage

// File: rtl/decoder_stream_if.sv
// Word-stream input and decoded-bundle output handshake of the Ember decoder.
// The decoder sits on the slave modport; the upstream/downstream side on master.
interface decoder_stream_if #(
  parameter int DATA_W = 64,
  parameter int INST_W = 32,
  parameter int REG_W  = 6
);
  logic [INST_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [11:0]       out_opcode;
  logic [3:0]        out_mode;
  logic [REG_W-1:0]  out_rsrc;
  logic [REG_W-1:0]  out_rdest;
  logic [3:0]        out_flags;
  logic [DATA_W-1:0] out_imm;
  logic              out_imm_en;
  logic              out_illegal;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_opcode, out_mode, out_rsrc, out_rdest, out_flags,
           out_imm, out_imm_en, out_illegal, out_valid
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_opcode, out_mode, out_rsrc, out_rdest, out_flags,
           out_imm, out_imm_en, out_illegal, out_valid
  );
endinterface

// File: rtl/decoder_stream_imm_assembler.sv
// Immediate assembler: down-counts remaining words, writes each word at its
// offset (first word in the LSBs) and extends the result above 2^k words.
module imm_assembler
  import ember_decode_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int INST_W        = 32,
  parameter int MAX_IMM_WORDS = 2,
  parameter int SIGN_EXT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_start,
  input  logic [1:0]        i_size,
  input  logic              i_word_we,
  input  logic [INST_W-1:0] i_word,
  output logic              o_last,
  output logic [DATA_W-1:0] o_imm
);
  localparam int CNT_W = (MAX_IMM_WORDS > 1) ? $clog2(MAX_IMM_WORDS) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_idx;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_next;
  logic              w_sign;
  int                w_nwords;

  assign o_last = (r_cnt == '0);

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[int'(r_idx)*INST_W +: INST_W] = i_word;
  end

  // Extension works in whole words since the received length is always 2^k words.
  always_comb begin
    w_nwords = 1 << r_size;
    w_sign   = w_acc_next[w_nwords*INST_W-1];
    o_imm    = w_acc_next;
    for (int j = 0; j < MAX_IMM_WORDS; j++) begin
      if (j >= w_nwords) begin
        o_imm[j*INST_W +: INST_W] = (SIGN_EXT != 0) ? {INST_W{w_sign}} : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_size <= '0;
      r_acc  <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_acc <= '0;
    end else if (i_start) begin
      r_cnt  <= CNT_W'((32'd1 << i_size) - 32'd1);
      r_idx  <= '0;
      r_size <= i_size;
      r_acc  <= '0;
    end else if (i_word_we) begin
      r_acc <= w_acc_next;
      if (!o_last) begin
        r_cnt <= r_cnt - 1'b1;
        r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/decoder_stream.sv
// Ember instruction decoder: header/immediate word stream in, one registered
// decoded bundle out.  state | meaning:  IDLE | next word is a header,
// IMM | collecting immediate words for the latched header.
module decoder_stream
  import ember_decode_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int INST_W        = 32,
  parameter int REG_W         = 6,
  parameter int MAX_IMM_WORDS = 2,
  parameter int SIGN_EXT      = 0
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  decoder_stream_if.slave bus
);
  state_t            r_state;
  hdr_t              r_hdr;
  bundle_t           r_out;
  logic [DATA_W-1:0] r_out_imm;
  logic              r_out_valid;

  hdr_t              w_word_hdr;
  logic [1:0]        w_size;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_hdr_accept;
  logic              w_imm_accept;
  logic              w_imm_start;
  logic              w_imm_last;
  logic [DATA_W-1:0] w_imm;

  assign w_word_hdr   = unpack_hdr(bus.in_word[HDR_W-1:0]);
  assign w_size       = w_word_hdr.flags[FLG_SZ +: 2];
  assign w_in_ready   = !flush && (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_hdr_accept = w_accept && (r_state == IDLE);
  assign w_imm_accept = w_accept && (r_state == IMM);
  assign w_imm_start  = w_hdr_accept && w_word_hdr.flags[FLG_I] &&
                        size_legal(w_size, MAX_IMM_WORDS);

  imm_assembler #(
    .DATA_W       (DATA_W),
    .INST_W       (INST_W),
    .MAX_IMM_WORDS(MAX_IMM_WORDS),
    .SIGN_EXT     (SIGN_EXT)
  ) u_imm (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (flush),
    .i_start  (w_imm_start),
    .i_size   (w_size),
    .i_word_we(w_imm_accept),
    .i_word   (bus.in_word),
    .o_last   (w_imm_last),
    .o_imm    (w_imm)
  );

  // A completion in the same cycle as a pop overrides the clear of out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hdr       <= '0;
      r_out       <= '0;
      r_out_imm   <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
      if (w_hdr_accept) begin
        r_hdr <= w_word_hdr;
        if (!w_word_hdr.flags[FLG_I]) begin
          if (w_word_hdr.flags[FLG_V]) begin
            r_out       <= '{hdr: w_word_hdr, imm_en: 1'b0, illegal: 1'b0};
            r_out_imm   <= '0;
            r_out_valid <= 1'b1;
          end
        end else if (!w_imm_start) begin
          r_out       <= '{hdr: w_word_hdr, imm_en: 1'b0, illegal: 1'b1};
          r_out_imm   <= '0;
          r_out_valid <= 1'b1;
        end else begin
          r_state <= IMM;
        end
      end
      if (w_imm_accept && w_imm_last) begin
        r_state <= IDLE;
        if (r_hdr.flags[FLG_V]) begin
          r_out       <= '{hdr: r_hdr, imm_en: 1'b1, illegal: 1'b0};
          r_out_imm   <= w_imm;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_opcode  = r_out.hdr.opcode;
  assign bus.out_mode    = r_out.hdr.mode;
  assign bus.out_rsrc    = REG_W'(r_out.hdr.rsrc);
  assign bus.out_rdest   = REG_W'(r_out.hdr.rdest);
  assign bus.out_flags   = r_out.hdr.flags;
  assign bus.out_imm     = r_out_imm;
  assign bus.out_imm_en  = r_out.imm_en;
  assign bus.out_illegal = r_out.illegal;
  assign bus.out_valid   = r_out_valid;
endmodule
